// File: rtl/grayscale_pkg.sv
// Shared types and constants for the grayscale read engine.
package grayscale_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDrain,
    StDone
  } t_rd_state;

  localparam int unsigned HC_CTRL_START_BIT  = 0;
  localparam int unsigned HC_LINE_BYTES_LOG2 = 6;

  typedef logic [26:0] t_rd_line_cnt;

  // Round a byte count up to whole cache lines; the 33-bit sum cannot overflow.
  function automatic t_rd_line_cnt bytes_to_lines(input logic [31:0] bytes);
    logic [32:0] sum;
    sum = {1'b0, bytes} + 33'((1 << HC_LINE_BYTES_LOG2) - 1);
    return t_rd_line_cnt'(sum >> HC_LINE_BYTES_LOG2);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/grayscale_rd_credit.sv
// Outstanding read-request tracker: counts in-flight lines against a fixed cap.
module grayscale_rd_credit #(
  parameter int unsigned MaxOutstanding = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic issue_i,
  input  logic rsp_i,
  output logic can_issue_o,
  output logic underflow_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (issue_i && !rsp_i) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (rsp_i && !issue_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign can_issue_o = (cnt_q < CntW'(MaxOutstanding));
  // Responses while idle belong to an abandoned transfer and are not errors.
  assign underflow_o = rsp_i && !issue_i && (cnt_q == '0) && !clear_i;

  assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= CntW'(MaxOutstanding));

endmodule

// File: rtl/grayscale_rd_engine.sv
// Buffer read engine: issues channel-0 line reads and forwards responses downstream.
// Define GRAYSCALE_RD_PERF_EN to add the three saturating performance counters.
module grayscale_rd_engine
  import grayscale_pkg::*;
#(
  parameter int unsigned ADDR_W          = 42,
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned MDATA_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        hc_control,
  input  logic [ADDR_W-1:0]  hc_buffer_address,
  input  logic [31:0]        hc_buffer_size,
  input  logic               c0TxAlmFull,
  output logic               rd_req_valid,
  output logic [ADDR_W-1:0]  rd_req_addr,
  output logic [MDATA_W-1:0] rd_req_mdata,
  input  logic               rd_rsp_valid,
  input  logic [MDATA_W-1:0] rd_rsp_mdata,
  input  logic [511:0]       rd_rsp_data,
  output logic               out_valid,
  output logic [MDATA_W-1:0] out_index,
  output logic [511:0]       out_data,
  output logic               busy,
`ifdef GRAYSCALE_RD_PERF_EN
  output logic [31:0]        perf_total_cycles,
  output logic [31:0]        perf_almfull_stall,
  output logic [31:0]        perf_credit_stall,
`endif
  output logic               done
);

  t_rd_state          state_q, state_d;
  logic               start_prev_q, start_prev_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  t_rd_line_cnt       total_q, total_d;
  t_rd_line_cnt       issued_q, issued_d;
  t_rd_line_cnt       received_q, received_d;
  logic               req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [MDATA_W-1:0] req_mdata_q, req_mdata_d;
  logic               out_valid_q, out_valid_d;
  logic [MDATA_W-1:0] out_index_q, out_index_d;
  logic [511:0]       out_data_q, out_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic start_bit, start_edge, pending, can_issue, issue, rsp_underflow, unused_ctrl;

  assign start_bit   = hc_control[HC_CTRL_START_BIT];
  assign unused_ctrl = ^(hc_control & ~(32'd1 << HC_CTRL_START_BIT));
  assign start_edge  = start_bit && !start_prev_q;
  assign pending     = (issued_q < total_q);
  assign issue       = (state_q == StReq) && !c0TxAlmFull && can_issue && pending;

  grayscale_rd_credit #(
    .MaxOutstanding(MAX_OUTSTANDING)
  ) u_credit (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clear_i    (state_q == StIdle),
    .issue_i    (issue),
    .rsp_i      (rd_rsp_valid),
    .can_issue_o(can_issue),
    .underflow_o(rsp_underflow)
  );

  always_comb begin
    state_d      = state_q;
    start_prev_d = start_bit;
    base_d       = base_q;
    total_d      = total_q;
    issued_d     = issued_q;
    received_d   = received_q;
    req_valid_d  = 1'b0;
    req_addr_d   = req_addr_q;
    req_mdata_d  = req_mdata_q;
    busy_d       = busy_q;
    done_d       = done_q;
    // Forwarding is unconditional so late responses still reach the pipeline.
    out_valid_d  = rd_rsp_valid;
    out_index_d  = rd_rsp_valid ? rd_rsp_mdata : out_index_q;
    out_data_d   = rd_rsp_valid ? rd_rsp_data : out_data_q;

    if ((state_q == StReq || state_q == StDrain) && rd_rsp_valid) begin
      received_d = received_q + t_rd_line_cnt'(1);
    end

    unique case (state_q)
      StIdle: begin
        issued_d   = '0;
        received_d = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        if (start_edge) begin
          base_d  = hc_buffer_address;
          total_d = bytes_to_lines(hc_buffer_size);
          if (bytes_to_lines(hc_buffer_size) == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StReq;
            busy_d  = 1'b1;
          end
        end
      end
      StReq: begin
        if (issue) begin
          req_valid_d = 1'b1;
          req_addr_d  = base_q + ADDR_W'(issued_q);
          req_mdata_d = MDATA_W'(issued_q);
          issued_d    = issued_q + t_rd_line_cnt'(1);
        end
        if (!pending) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (received_q == total_q) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        if (!start_bit) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b0;
      base_q       <= '0;
      total_q      <= '0;
      issued_q     <= '0;
      received_q   <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_mdata_q  <= '0;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      base_q       <= base_d;
      total_q      <= total_d;
      issued_q     <= issued_d;
      received_q   <= received_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      req_mdata_q  <= req_mdata_d;
      out_valid_q  <= out_valid_d;
      out_index_q  <= out_index_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_req_valid = req_valid_q;
  assign rd_req_addr  = req_addr_q;
  assign rd_req_mdata = req_mdata_q;
  assign out_valid    = out_valid_q;
  assign out_index    = out_index_q;
  assign out_data     = out_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef GRAYSCALE_RD_PERF_EN
  logic [31:0] perf_total_q, perf_total_d;
  logic [31:0] perf_alm_q, perf_alm_d;
  logic [31:0] perf_credit_q, perf_credit_d;

  always_comb begin
    perf_total_d  = perf_total_q;
    perf_alm_d    = perf_alm_q;
    perf_credit_d = perf_credit_q;
    if (state_q == StIdle && start_edge) begin
      perf_total_d  = '0;
      perf_alm_d    = '0;
      perf_credit_d = '0;
    end else if (state_q == StReq || state_q == StDrain) begin
      perf_total_d = sat_inc32(perf_total_q);
      if (state_q == StReq && pending) begin
        if (c0TxAlmFull) perf_alm_d = sat_inc32(perf_alm_q);
        if (!can_issue) perf_credit_d = sat_inc32(perf_credit_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_total_q  <= '0;
      perf_alm_q    <= '0;
      perf_credit_q <= '0;
    end else begin
      perf_total_q  <= perf_total_d;
      perf_alm_q    <= perf_alm_d;
      perf_credit_q <= perf_credit_d;
    end
  end

  assign perf_total_cycles  = perf_total_q;
  assign perf_almfull_stall = perf_alm_q;
  assign perf_credit_stall  = perf_credit_q;
`endif

  assert property (@(posedge clk) disable iff (!reset) !rsp_underflow);

endmodule

// File: tb/tb_grayscale_rd_engine.sv
// Directed bench for grayscale_rd_engine with a per-cycle reference model of requests/responses.
module tb_grayscale_rd_engine;

  localparam int unsigned ADDR_W  = 42;
  localparam int unsigned MAX_OUT = 64;
  localparam int unsigned MDATA_W = 16;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [MDATA_W-1:0] mdata;
  } req_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        hc_control;
  logic [ADDR_W-1:0]  hc_buffer_address;
  logic [31:0]        hc_buffer_size;
  logic               c0TxAlmFull;
  logic               rd_req_valid;
  logic [ADDR_W-1:0]  rd_req_addr;
  logic [MDATA_W-1:0] rd_req_mdata;
  logic               rd_rsp_valid;
  logic [MDATA_W-1:0] rd_rsp_mdata;
  logic [511:0]       rd_rsp_data;
  logic               out_valid;
  logic [MDATA_W-1:0] out_index;
  logic [511:0]       out_data;
  logic               busy;
  logic               done;
`ifdef GRAYSCALE_RD_PERF_EN
  logic [31:0] perf_total_cycles, perf_almfull_stall, perf_credit_stall;
`endif

  always #5 clk = ~clk;

  grayscale_rd_engine #(
    .ADDR_W(ADDR_W),
    .MAX_OUTSTANDING(MAX_OUT),
    .MDATA_W(MDATA_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .hc_control       (hc_control),
    .hc_buffer_address(hc_buffer_address),
    .hc_buffer_size   (hc_buffer_size),
    .c0TxAlmFull      (c0TxAlmFull),
    .rd_req_valid     (rd_req_valid),
    .rd_req_addr      (rd_req_addr),
    .rd_req_mdata     (rd_req_mdata),
    .rd_rsp_valid     (rd_rsp_valid),
    .rd_rsp_mdata     (rd_rsp_mdata),
    .rd_rsp_data      (rd_rsp_data),
    .out_valid        (out_valid),
    .out_index        (out_index),
    .out_data         (out_data),
    .busy             (busy),
`ifdef GRAYSCALE_RD_PERF_EN
    .perf_total_cycles (perf_total_cycles),
    .perf_almfull_stall(perf_almfull_stall),
    .perf_credit_stall (perf_credit_stall),
`endif
    .done             (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int req_seen = 0;
  int out_seen = 0;
  int model_out = 0;
  int start_cyc, alm_start, alm_end;
  int rel_cnt = 0;
  bit auto_rsp = 1'b0;
  bit rev_rsp  = 1'b0;

  req_t               exp_req[$];
  req_t               e;
  logic [MDATA_W-1:0] tags[$];
  int                 req_cyc[$];
  logic [ADDR_W-1:0]  first_addr;
  logic [MDATA_W-1:0] first_idx, last_idx, rtag;
  logic               c_rsp, c_alm, c_rst;
  logic [MDATA_W-1:0] c_idx;
  logic [511:0]       c_data;

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_v(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] line_data(input logic [MDATA_W-1:0] tag);
    return {16{16'hA5C3, tag}};
  endfunction

  // Reference model: outputs are the inputs delayed one cycle; requests follow the line
  // order, never under almfull, never beyond the in-flight cap.
  always begin
    @(posedge clk);
    c_rsp  = rd_rsp_valid;
    c_idx  = rd_rsp_mdata;
    c_data = rd_rsp_data;
    c_alm  = c0TxAlmFull;
    c_rst  = reset;
    #1;
    cyc++;
    check_i("out_valid", int'(out_valid), int'(c_rsp && c_rst));
    if (out_valid) begin
      check_i("out_index", int'(out_index), int'(c_idx));
      check_v("out_data", out_data, c_data);
      if (out_seen == 0) first_idx = out_index;
      last_idx = out_index;
      out_seen++;
    end
    if (rd_req_valid) begin
      check_i("req_under_almfull", int'(c_alm), 0);
      check_i("req_within_cap", int'(model_out < int'(MAX_OUT)), 1);
      if (exp_req.size() == 0) begin
        check_i("req_unexpected", int'(rd_req_valid), 0);
      end else begin
        e = exp_req.pop_front();
        check_v("req_addr", 512'(rd_req_addr), 512'(e.addr));
        check_i("req_mdata", int'(rd_req_mdata), int'(e.mdata));
      end
      if (req_seen == 0) first_addr = rd_req_addr;
      req_seen++;
      req_cyc.push_back(cyc);
      tags.push_back(rd_req_mdata);
      model_out++;
    end
    if (!c_rst) model_out = 0;
    else if (c_rsp && model_out > 0) model_out--;
  end

  // Responder: automatic (one per cycle) or released one at a time, FIFO or LIFO order.
  always begin
    @(negedge clk);
    #1;
    if ((auto_rsp || rel_cnt > 0) && tags.size() > 0) begin
      rtag = rev_rsp ? tags.pop_back() : tags.pop_front();
      rd_rsp_valid = 1'b1;
      rd_rsp_mdata = rtag;
      rd_rsp_data  = line_data(rtag);
      if (!auto_rsp) rel_cnt--;
    end else begin
      rd_rsp_valid = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] base, input logic [31:0] size);
    longint lines;
    req_t r;
    lines = (longint'(size) + 63) / 64;
    for (longint i = 0; i < lines; i++) begin
      r.addr  = base + ADDR_W'(i);
      r.mdata = MDATA_W'(i);
      exp_req.push_back(r);
    end
    req_seen = 0;
    out_seen = 0;
    req_cyc.delete();
    hc_buffer_address = base;
    hc_buffer_size    = size;
    hc_control        = 32'h8000_0001;
    start_cyc         = cyc;
  endtask

  task automatic stop_xfer();
    hc_control = 32'h0;
    tick(3);
    check_i("done_cleared", int'(done), 0);
    check_i("busy_idle", int'(busy), 0);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && !done; k++) tick(1);
    check_i("done_reached", int'(done), 1);
    check_i("busy_at_done", int'(busy), 0);
  endtask

  task automatic wait_reqs(input int n, input int budget);
    for (int k = 0; k < budget && req_seen < n; k++) tick(1);
    check_i("reqs_reached", int'(req_seen >= n), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_i({tag, "_rd_req_valid"}, int'(rd_req_valid), 0);
    check_v({tag, "_rd_req_addr"}, 512'(rd_req_addr), 512'(0));
    check_i({tag, "_rd_req_mdata"}, int'(rd_req_mdata), 0);
    check_i({tag, "_out_valid"}, int'(out_valid), 0);
    check_i({tag, "_out_index"}, int'(out_index), 0);
    check_v({tag, "_out_data"}, out_data, 512'(0));
    check_i({tag, "_busy"}, int'(busy), 0);
    check_i({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running after 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt_in, found;
    reset             = 1'b0;
    hc_control        = 32'h0;
    hc_buffer_address = '0;
    hc_buffer_size    = 32'h0;
    c0TxAlmFull       = 1'b0;
    rd_rsp_valid      = 1'b0;
    rd_rsp_mdata      = '0;
    rd_rsp_data       = '0;
    tick(3);
    check_outputs_zero("reset");
    reset = 1'b1;
    tick(2);

    // 4 lines, immediate responses; later input changes must be ignored.
    auto_rsp = 1'b1;
    start_xfer(42'h1000, 32'd256);
    tick(1);
    hc_buffer_size    = 32'd64000;
    hc_buffer_address = 42'h3FF_0000;
    wait_done(50);
    check_i("t1_req_count", req_seen, 4);
    check_i("t1_out_count", out_seen, 4);
    for (int i = 0; i < 4 && i < req_cyc.size(); i++)
      check_i("t1_req_cycle", req_cyc[i], start_cyc + 2 + i);
    check_v("t1_first_addr", 512'(first_addr), 512'(42'h1000));
    check_i("t1_last_index", int'(last_idx), 3);
    stop_xfer();

    // Single byte -> one line.
    start_xfer(42'h7FF, 32'd1);
    wait_done(30);
    check_i("t2_req_count", req_seen, 1);
    check_v("t2_first_addr", 512'(first_addr), 512'(42'h7FF));
    stop_xfer();

    // Zero bytes -> straight to done, never busy.
    start_xfer(42'h100, 32'd0);
    tick(1);
    check_i("t2z_busy", int'(busy), 0);
    tick(1);
    check_i("t2z_busy", int'(busy), 0);
    check_i("t2z_done", int'(done), 1);
    tick(3);
    check_i("t2z_req_count", req_seen, 0);
    stop_xfer();

    // Credit cap: 200 lines with responses withheld.
    auto_rsp = 1'b0;
    start_xfer(42'h10000, 32'd12800);
    tick(100);
    check_i("t3_capped", req_seen, 64);
    check_i("t3_busy", int'(busy), 1);
    check_i("t3_not_done", int'(done), 0);
    rel_cnt = 1;
    tick(10);
    check_i("t3_one_more", req_seen, 65);
    auto_rsp = 1'b1;
    wait_done(1000);
    check_i("t3_req_count", req_seen, 200);
    check_i("t3_out_count", out_seen, 200);
    stop_xfer();

    // Almost-full window of 10 cycles mid-transfer.
    start_xfer(42'h4000, 32'd2560);
    wait_reqs(5, 20);
    c0TxAlmFull = 1'b1;
    alm_start = cyc;
    tick(10);
    c0TxAlmFull = 1'b0;
    alm_end = cyc;
    tick(3);
    cnt_in = 0;
    found  = 0;
    foreach (req_cyc[i]) begin
      if (req_cyc[i] > alm_start && req_cyc[i] <= alm_end) cnt_in++;
      if (req_cyc[i] == alm_end + 1) found = 1;
    end
    check_i("t4_reqs_in_window", cnt_in, 0);
    check_i("t4_resume_next_cycle", found, 1);
    wait_done(500);
    check_i("t4_req_count", req_seen, 40);
`ifdef GRAYSCALE_RD_PERF_EN
    check_i("t4_perf_almfull", int'(perf_almfull_stall), 10);
`endif
    stop_xfer();

    // LIFO responses, first one overlapping an issue cycle.
    auto_rsp = 1'b0;
    rev_rsp  = 1'b1;
    start_xfer(42'h5000, 32'd384);
    wait_reqs(3, 20);
    rel_cnt = 1;
    wait_reqs(6, 20);
    tick(2);
    rel_cnt = 5;
    wait_done(50);
    check_i("t5_req_count", req_seen, 6);
    check_i("t5_out_count", out_seen, 6);
    check_i("t5_first_index", int'(first_idx), 2);
    check_i("t5_last_index", int'(last_idx), 0);
    rev_rsp = 1'b0;
    stop_xfer();

    // Reset in DRAIN with 5 outstanding, then a fresh transfer.
    start_xfer(42'h3000, 32'd320);
    wait_reqs(5, 20);
    tick(3);
    check_i("t6_busy_drain", int'(busy), 1);
    check_i("t6_not_done", int'(done), 0);
    reset      = 1'b0;
    hc_control = 32'h0;
    exp_req.delete();
    tags.delete();
    tick(1);
    check_outputs_zero("t6_reset");
    reset = 1'b1;
    tick(2);
    auto_rsp = 1'b1;
    start_xfer(42'h2000, 32'd128);
    wait_done(30);
    check_i("t6_req_count", req_seen, 2);
    check_i("t6_out_count", out_seen, 2);
    check_v("t6_first_addr", 512'(first_addr), 512'(42'h2000));
    stop_xfer();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
